// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with enable, load, polarity select and auto-scan
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   en              0 blanks dout and freezes the sequencer
//   mode            0 direct decode of cur_sel, 1 auto-scan
//   load, sel       load strobe captures sel as the decoded index
//   dwell           scan slot length minus 1, sampled every cycle
//   dout            registered one-hot output, inverted when ACTIVE_LOW
//   cur_sel         currently decoded index
//   wrap            one-cycle pulse when the scan wraps last->0
module decoder_scan #(
  parameter int SEL_W      = 2,
  parameter int DWELL_W    = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(1<<SEL_W)-1:0] dout,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  wrap
);
  localparam int OUT_W = 1 << SEL_W;
  localparam logic [OUT_W-1:0] INACT = ACTIVE_LOW ? '1 : '0;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]   dout_q, dout_d;
  logic               act_q, act_d, wrap_q, wrap_d;
  // Slot advance uses >= so shrinking dwell below the running count advances at once.
  always_comb begin
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    act_d  = en;
    wrap_d = 1'b0;
    if (en) begin
      cnt_d = '0;
      if (load) sel_d = sel;
      else if (act_q && mode) begin
        if (cnt_q >= dwell) begin
          sel_d  = sel_q + 1'b1;
          wrap_d = &sel_q;
        end else cnt_d = cnt_q + 1'b1;
      end
    end
    // XOR with the inactive pattern flips the single active bit for either polarity.
    dout_d = en ? (INACT ^ (OUT_W'(1) << sel_d)) : INACT;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      act_q  <= 1'b0;
      wrap_q <= 1'b0;
      dout_q <= INACT;
    end else begin
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      wrap_q <= wrap_d;
      dout_q <= dout_d;
    end
  end
  assign dout    = dout_q;
  assign cur_sel = sel_q;
  assign wrap    = wrap_q;
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: vector table with scoreboard for active-high and active-low decoder_scan
module tb_decoder_scan;
  typedef struct {
    logic       rst_n, en, mode, load;
    logic [1:0] sel;
    logic [3:0] dwell;
    logic [3:0] dout;
    logic [1:0] cs;
    logic       wrap;
  } vec_t;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, mode = 1'b0, load = 1'b0;
  logic [1:0] sel = '0, cs0, cs1;
  logic [3:0] dwell = '0, dout0, dout1;
  logic       wrap0, wrap1;
  int         n_chk = 0, n_fail = 0;
  vec_t       tbl[$];
  vec_t       exp_q[$];
  always #5 clk = ~clk;
  decoder_scan #(.SEL_W(2), .DWELL_W(4), .ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .sel(sel),
    .dwell(dwell), .dout(dout0), .cur_sel(cs0), .wrap(wrap0));
  decoder_scan #(.SEL_W(2), .DWELL_W(4), .ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .sel(sel),
    .dwell(dwell), .dout(dout1), .cur_sel(cs1), .wrap(wrap1));
  task automatic add(input logic r, e, m, l, input logic [1:0] s, input logic [3:0] d,
                     input logic [3:0] o, input logic [1:0] c, input logic w);
    vec_t t;
    t.rst_n = r; t.en = e; t.mode = m; t.load = l; t.sel = s; t.dwell = d;
    t.dout = o; t.cs = c; t.wrap = w;
    tbl.push_back(t);
  endtask
  task automatic chk(input string nm, input int i, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %b expected %b", nm, i, act, exp);
    end
  endtask
  function automatic logic [3:0] oh(input int s);
    logic [3:0] one = 4'b0001;
    return one << s;
  endfunction
  initial begin
    vec_t t, x;
    // reset with en=1, mode=1
    add(0, 1, 1, 0, 0, 2, 4'b0000, 0, 0);
    // direct sweep, then hold
    for (int s = 0; s < 4; s++) add(1, 1, 0, 1, 2'(s), 0, oh(s), 2'(s), 0);
    add(1, 1, 0, 0, 0, 0, 4'b1000, 3, 0);
    add(1, 1, 0, 0, 1, 0, 4'b1000, 3, 0);
    // scan dwell=2 from reset: four slots of 3 cycles then wrap
    add(0, 1, 1, 0, 0, 2, 4'b0000, 0, 0);
    for (int s = 0; s < 5; s++)
      for (int k = 0; k < 3; k++) add(1, 1, 1, 0, 0, 2, oh(s % 4), 2'(s % 4), s == 4 && k == 0);
    // dwell=0: advance every cycle, wrap every 4th
    for (int k = 1; k <= 8; k++) add(1, 1, 1, 0, 0, 0, oh(k % 4), 2'(k % 4), k % 4 == 0);
    // dwell 0->3: current slot and next last 4 cycles
    for (int k = 0; k < 3; k++) add(1, 1, 1, 0, 0, 3, 4'b0001, 0, 0);
    for (int k = 0; k < 4; k++) add(1, 1, 1, 0, 0, 3, 4'b0010, 1, 0);
    // dwell shrunk below cnt=3 advances immediately
    add(1, 1, 1, 0, 0, 1, 4'b0100, 2, 0);
    add(1, 1, 1, 0, 0, 1, 4'b0100, 2, 0);
    add(1, 1, 1, 0, 0, 1, 4'b1000, 3, 0);
    // mode 1->0 mid-slot holds
    add(1, 1, 0, 0, 0, 1, 4'b1000, 3, 0);
    add(1, 1, 0, 0, 0, 1, 4'b1000, 3, 0);
    // disable at cur_sel=1, cnt=1 (dwell=2)
    add(0, 1, 1, 0, 0, 2, 4'b0000, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 1, 1, 0, 0, 2, 4'b0001, 0, 0);
    add(1, 1, 1, 0, 0, 2, 4'b0010, 1, 0);
    add(1, 1, 1, 0, 0, 2, 4'b0010, 1, 0);
    add(1, 0, 1, 0, 0, 2, 4'b0000, 1, 0);
    add(1, 0, 1, 1, 3, 2, 4'b0000, 1, 0);
    add(1, 0, 1, 0, 0, 2, 4'b0000, 1, 0);
    for (int k = 0; k < 3; k++) add(1, 1, 1, 0, 0, 2, 4'b0010, 1, 0);
    // load sel=3 restarts the slot, then wrap into 0
    add(1, 1, 1, 1, 3, 2, 4'b1000, 3, 0);
    add(1, 1, 1, 0, 0, 2, 4'b1000, 3, 0);
    add(1, 1, 1, 0, 0, 2, 4'b1000, 3, 0);
    add(1, 1, 1, 0, 0, 2, 4'b0001, 0, 1);
    // direct sel=2 then reset mid-scan and restart
    add(1, 1, 0, 1, 2, 2, 4'b0100, 2, 0);
    add(1, 1, 1, 0, 0, 2, 4'b0100, 2, 0);
    add(1, 1, 1, 0, 0, 2, 4'b0100, 2, 0);
    add(0, 1, 1, 0, 0, 2, 4'b0000, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 1, 1, 0, 0, 2, 4'b0001, 0, 0);
    add(1, 1, 1, 0, 0, 2, 4'b0010, 1, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      @(negedge clk);
      rst_n = t.rst_n; en = t.en; mode = t.mode; load = t.load; sel = t.sel; dwell = t.dwell;
      exp_q.push_back(t);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      chk("dout", i, dout0, x.dout);
      chk("dout_al", i, dout1, ~x.dout);
      chk("cur_sel", i, {2'b00, cs0}, {2'b00, x.cs});
      chk("cur_sel_al", i, {2'b00, cs1}, {2'b00, x.cs});
      chk("wrap", i, {3'b000, wrap0}, {3'b000, x.wrap});
      chk("wrap_al", i, {3'b000, wrap1}, {3'b000, x.wrap});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised, registered successor to the team's 2-to-4 line decoder: SEL_W-bit select decoded to a 2**SEL_W one-hot output.
- Adds an enable, a load strobe, output polarity selection and an auto-scan mode in which an internal sequencer walks the outputs with a programmable dwell time.
- Used as the digit/row strobe generator for multiplexed displays and keypad scanning, and as a plain registered decoder elsewhere.

Parameters:
- SEL_W, 2, select width; output width OUT_W = 2**SEL_W (SEL_W range 1..6).
- DWELL_W, 4, width of dwell input and internal dwell counter.
- ACTIVE_LOW, 0, 1 = dout bitwise inverted (active output 0, inactive 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  enable; 0 forces dout inactive and freezes the sequencer.
- mode  in  1  0 = direct decode, 1 = auto-scan.
- load  in  1  strobe: capture sel into cur_sel.
- sel  in  SEL_W  select value, sampled when load=1.
- dwell  in  DWELL_W  scan slot length minus 1, sampled live every cycle.
- dout  out  OUT_W  registered one-hot output (polarity per ACTIVE_LOW).
- cur_sel  out  SEL_W  currently decoded index.
- wrap  out  1  one-cycle pulse on scan wrap last->0.

Behaviour:
- Inactive value of dout: all 0 (ACTIVE_LOW=0) or all 1 (ACTIVE_LOW=1). onehot(i) = bit i active, others inactive.
- Internal state: cur_sel, cnt (DWELL_W bits), act_q (1 bit; dout currently active).
- Reset (rst_n=0 at an edge, overrides everything, any time including mid-scan): dout=inactive, cur_sel=0, cnt=0, act_q=0, wrap=0.
- All updates on the rising clk edge; dout, cur_sel and wrap are registered with 1-cycle latency from inputs. wrap=0 on every edge unless stated otherwise.
- en=0: dout<=inactive, act_q<=0, cur_sel and cnt hold, load ignored.
- en=1, priority order:
  1. load=1 (either mode): cur_sel<=sel, dout<=onehot(sel), cnt<=0, act_q<=1.
  2. act_q=0 (first enabled edge after reset or disable): dout<=onehot(cur_sel), cnt<=0, act_q<=1, no advance.
  3. mode=0: dout<=onehot(cur_sel) (hold), cnt<=0.
  4. mode=1 and cnt>=dwell: cur_sel<=cur_sel+1 mod 2**SEL_W, dout<=onehot(next), cnt<=0. wrap<=1 iff cur_sel was 2**SEL_W-1.
  5. mode=1 otherwise: cnt<=cnt+1, dout holds.
- Each scan slot is visible for exactly dwell+1 cycles, including the first slot after enable, load or reset.
- dwell reduced below the current cnt: the ">=" compare advances on the next edge; there is no counter overflow.
- dwell=0: output advances every cycle.
- Switching mode 0->1: the scan starts from cur_sel with cnt=0. Switching 1->0 mid-slot: dout holds the current index.
- Direct mode with en=1: combinational equivalence to the 2-to-4 truth table, delayed one cycle (SEL_W=2: 0->0001, 1->0010, 2->0100, 3->1000).

Test Plan:
- Reset: SEL_W=2, rst_n=0 for 1 edge with en=1, mode=1 -> dout=4'b0000, cur_sel=0, wrap=0.
- Direct sweep: mode=0, en=1, load=1, sel=0,1,2,3 on consecutive edges -> dout=0001,0010,0100,1000 one cycle later each; then load=0 -> dout holds 1000.
- Scan dwell=2 from reset, en=1, mode=1:
  - dout=0001,0010,0100,1000, each for exactly 3 cycles, then 0001 again.
  - wrap=1 only in the first cycle of the returned 0001 slot.
- Scan dwell=0: dout rotates every cycle 0001->0010->0100->1000->0001; wrap high every 4th cycle. Change dwell 0->3 mid-run -> next slot lasts 4 cycles.
- Disable/load mid-scan (dwell=2): at cur_sel=1, cnt=1, drop en for 3 cycles -> dout=0000, cur_sel=1 held. Re-enable -> 0010 for 3 full cycles. Then assert load=1 with sel=3 -> dout=1000 next cycle, slot restarts (3 cycles), then 0001 with wrap=1.
- ACTIVE_LOW=1 plus reset mid-scan: reset -> dout=1111. Direct sel=2 -> 1011. During scan assert rst_n=0 -> next edge dout=1111, cur_sel=0; release -> scan restarts at 1110.
